join_multi_key: RTL
===================

# join_multi_key

Parametrised multi-key stream join: loads a query set of up to DEPTH keys from the AXI4S query stream, then probes a batch of tuple keys from the meta stream against the whole set, producing one registered hit/miss result per probe. It replaces the single-key comparator in the streaming join datapath and adds anti-join mode, match index and per-batch hit counting. It sits between the query-key FIFO and the downstream aggregation/filter stage.

## Interface
- KEY_BITS, 64, width of query and probe keys
- DEPTH, 16, max keys held in the query set (power of 2, ≥2)
- ANTI, 0, 0 = semi-join (hit on match), 1 = anti-join (hit on no match)
- IDX_BITS, $clog2(DEPTH), derived; width of match index

- aclk  in  1  clock; all logic rising-edge
- areset  in  1  synchronous, active-high reset
- s_axis_tvalid / s_axis_tready  in / out  1  query-key handshake
- s_axis_tdata  in  KEY_BITS  one query key per beat
- s_axis_tlast  in  1  last key of the query set
- s_meta_valid / s_meta_ready  in / out  1  probe handshake
- s_meta_key  in  KEY_BITS  probe key
- s_meta_last  in  1  last probe of the batch
- m_meta_valid / m_meta_ready  out / in  1  result handshake
- m_meta_hit  out  1  join result (polarity per ANTI)
- m_meta_idx  out  IDX_BITS  lowest matching set index; 0 if no match
- m_meta_last  out  1  copy of s_meta_last
- m_meta_cnt  out  32  hits in current batch including this beat, saturating at 2^32-1
- overflow  out  1  sticky: current query set exceeded DEPTH

## Operation
- Two states: LOAD, PROBE. Reset → LOAD, key count 0, overflow 0, hit counter 0, m_meta_valid 0, all m_meta_* data 0.
- LOAD: s_axis_tready = 1, s_meta_ready = 0. Each accepted beat writes tdata to slot[count], count+1, if count < DEPTH; otherwise the key is dropped and overflow set. Accepted beat with tlast → PROBE (also on a dropped beat). tlast on first beat gives a one-key set.
- overflow clears on the first accepted beat of the next LOAD.
- PROBE: s_axis_tready = 0. s_meta_ready = !m_meta_valid || m_meta_ready (one-deep output register, full throughput).
- On accepted probe: match = OR over i<count of (slot[i] == key), full-width compare; slots ≥ count never match. m_meta_hit = match XOR ANTI; m_meta_idx = lowest matching i; m_meta_cnt = batch hit counter + hit; m_meta_last = s_meta_last.
- Accepted probe with s_meta_last = 1: count ← 0, batch hit counter ← 0, state → LOAD. Stale slot contents are irrelevant.
- Empty set (count 0) impossible after a load; a tlast-only overflowed set keeps DEPTH keys.
- Result register holds stable while m_meta_valid && !m_meta_ready.

## Timing
- Probe-to-result latency: 1 cycle (accepted at edge N → m_meta_valid high after edge N).
- Throughput: 1 probe/cycle with m_meta_ready held high; 1 key/cycle in LOAD.
- LOAD→PROBE: first probe may be accepted in the cycle after the tlast beat.
- PROBE→LOAD: s_axis_tready high in the cycle after the last probe is accepted; the last result may still be pending in the output register and drains independently.
- Backpressure: m_meta_ready low with result pending → s_meta_ready low same cycle (combinational).
- areset mid-operation: next edge returns to reset values; pending result discarded; in-flight keys lost.

## Test plan
- Load keys {5,9,9,42} (tlast on 42); probes 9, 7, 42(last), ANTI=0 → hit 1/0/1, idx 1/0/3, cnt 1/1/2, last on third; s_axis_tready high next cycle.
- Same set, ANTI=1 → hits 0/1/0, cnt 0/1/1.
- DEPTH=4, load 6 keys {1..6} → overflow=1, probe 5 and 4 → hit 0 and 1; next load of {7} clears overflow on its first beat.
- Back-to-back probes with m_meta_ready toggling 1,0,0,1 → no result lost or duplicated, data stable while stalled, s_meta_ready follows the rule.
- Two consecutive load/probe rounds; second round's set {100} with probe 5 → miss (old slots ignored), cnt restarts at 0.
- Assert areset during PROBE with result pending → m_meta_valid 0, overflow 0, state LOAD, s_axis_tready 1 after release.

Source files
------------

// File: rtl/join_multi_key.sv
// join_multi_key: multi-key stream join. Loads a query set of up to DEPTH keys
// from the query stream, then probes a batch of keys from the meta stream
// against the whole set, producing one registered hit/miss result per probe.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_LOAD  | accepting query keys into slot[count] until a tlast beat
// ST_PROBE | accepting probes; one registered result per probe until last
module join_multi_key #(
   parameter int KEY_BITS = 64,
   parameter int DEPTH    = 16,
   parameter int ANTI     = 0,
   parameter int IDX_BITS = $clog2(DEPTH)
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   input  logic [KEY_BITS-1:0] s_axis_tdata,
   input  logic                s_axis_tlast,
   input  logic                s_meta_valid,
   output logic                s_meta_ready,
   input  logic [KEY_BITS-1:0] s_meta_key,
   input  logic                s_meta_last,
   output logic                m_meta_valid,
   input  logic                m_meta_ready,
   output logic                m_meta_hit,
   output logic [IDX_BITS-1:0] m_meta_idx,
   output logic                m_meta_last,
   output logic [31:0]         m_meta_cnt,
   output logic                overflow
);

   // count must hold 0..DEPTH inclusive, hence one bit wider than the index
   localparam int                CNT_BITS  = IDX_BITS + 1;
   localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(DEPTH);
   localparam logic              ANTI_BIT  = (ANTI != 0);

   typedef enum logic {
      ST_LOAD  = 1'b0,
      ST_PROBE = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_BITS-1:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic [31:0]           batch_cnt_q, batch_cnt_d;
   logic [KEY_BITS-1:0]   slot_q [DEPTH];
   logic [KEY_BITS-1:0]   slot_d [DEPTH];

   logic                  out_valid_q, out_valid_d;
   logic                  out_hit_q, out_hit_d;
   logic [IDX_BITS-1:0]   out_idx_q, out_idx_d;
   logic                  out_last_q, out_last_d;
   logic [31:0]           out_cnt_q, out_cnt_d;

   logic                  load_ready;
   logic                  probe_ready;
   logic                  load_fire;
   logic                  probe_fire;
   logic                  slot_we;
   logic                  probe_match;
   logic [IDX_BITS-1:0]   probe_idx;
   logic                  probe_hit;
   logic [31:0]           batch_cnt_next;

   // Handshake readies: LOAD takes keys, PROBE takes probes while the
   // one-deep result register is empty or being drained this cycle.
   assign load_ready  = (state_q == ST_LOAD);
   assign probe_ready = (state_q == ST_PROBE) && (!out_valid_q || m_meta_ready);
   assign load_fire   = load_ready && s_axis_tvalid;
   assign probe_fire  = probe_ready && s_meta_valid;

   assign s_axis_tready = load_ready;
   assign s_meta_ready  = probe_ready;

   // Associative compare of the probe against every occupied slot; the
   // downward scan leaves the lowest matching index in probe_idx.
   always_comb begin
      probe_match = 1'b0;
      probe_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if ((CNT_BITS'(i) < count_q) && (slot_q[i] == s_meta_key)) begin
            probe_match = 1'b1;
            probe_idx   = IDX_BITS'(i);
         end
      end
   end

   // Join polarity and saturating per-batch hit count including this probe.
   always_comb begin
      probe_hit      = probe_match ^ ANTI_BIT;
      batch_cnt_next = batch_cnt_q;
      if (probe_hit && (batch_cnt_q != 32'hFFFF_FFFF)) begin
         batch_cnt_next = batch_cnt_q + 32'd1;
      end
   end

   // Next-state logic: key loading, overflow tracking, batch bookkeeping.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      batch_cnt_d = batch_cnt_q;
      slot_we     = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (load_fire) begin
               // count is zero only on the first beat of a fresh query set
               if (count_q == '0) begin
                  overflow_d = 1'b0;
               end
               if (count_q < DEPTH_CNT) begin
                  slot_we = 1'b1;
                  count_d = count_q + 1'b1;
               end else begin
                  overflow_d = 1'b1;
               end
               if (s_axis_tlast) begin
                  state_d = ST_PROBE;
               end
            end
         end
         ST_PROBE: begin
            if (probe_fire) begin
               batch_cnt_d = batch_cnt_next;
               if (s_meta_last) begin
                  count_d     = '0;
                  batch_cnt_d = '0;
                  state_d     = ST_LOAD;
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   // Slot array write; old contents beyond count are never consulted.
   always_comb begin
      slot_d = slot_q;
      if (slot_we) begin
         slot_d[count_q[IDX_BITS-1:0]] = s_axis_tdata;
      end
   end

   // One-deep result register: load on probe, hold while stalled.
   always_comb begin
      out_valid_d = out_valid_q;
      out_hit_d   = out_hit_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      out_cnt_d   = out_cnt_q;
      if (probe_fire) begin
         out_valid_d = 1'b1;
         out_hit_d   = probe_hit;
         out_idx_d   = probe_idx;
         out_last_d  = s_meta_last;
         out_cnt_d   = batch_cnt_next;
      end else if (m_meta_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Control and result registers with synchronous reset.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= ST_LOAD;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         batch_cnt_q <= '0;
         out_valid_q <= 1'b0;
         out_hit_q   <= 1'b0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         out_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         batch_cnt_q <= batch_cnt_d;
         out_valid_q <= out_valid_d;
         out_hit_q   <= out_hit_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         out_cnt_q   <= out_cnt_d;
      end
   end

   // Key storage needs no reset: count gates every compare.
   always_ff @(posedge aclk) begin
      slot_q <= slot_d;
   end

   assign m_meta_valid = out_valid_q;
   assign m_meta_hit   = out_hit_q;
   assign m_meta_idx   = out_idx_q;
   assign m_meta_last  = out_last_q;
   assign m_meta_cnt   = out_cnt_q;
   assign overflow     = overflow_q;

endmodule
